sm4_sbox_sched: RTL



---
 rtl/sm4_pkg.sv | 31 +++
 rtl/sbox_memory.sv | 38 +++
 rtl/sm4_rr_arb2.sv | 32 +++
 rtl/sm4_sbox_sched.sv | 126 ++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sm4_pkg
// Description : Shared types for the SM4 control blocks: the 32-bit word
//               type, the requester source encoding and the S-box
//               scheduler state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sm4_pkg;

  typedef logic [31:0] sm4_word_t;

  typedef enum logic {
    SM4_SRC_KEY = 1'b0,
    SM4_SRC_RND = 1'b1
  } sm4_src_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    DONE   = 2'd2
  } sbox_sched_state_e;

  // Only 1, 2 or 4 lookup engines divide a word evenly.
  function automatic logic num_sbox_legal(input int n);
    return (n == 1) || (n == 2) || (n == 4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_memory.sv
`default_nettype none
// ============================================================================
// Module      : sbox_memory
// Description : SM4 8-bit S-box, combinational ROM.
// Ports       : addr_i [7:0]  input byte
//               data_o [7:0]  S(addr_i)
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_memory (
  input  logic [7:0] addr_i,
  output logic [7:0] data_o
);

  // One 16-byte row per high nibble; the leftmost byte of each row is
  // column 0, so the column is selected from the top of the row down.
  localparam logic [127:0] c_sbox_rows [16] = '{
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  assign data_o = c_sbox_rows[addr_i[7:4]][{~addr_i[3:0], 3'b000} +: 8];

endmodule
`default_nettype wire

// File: rtl/sm4_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : sm4_rr_arb2
// Description : Two-input round-robin arbiter. On a tie the requester that
//               did not win last time is granted.
// Ports       : req [1:0]   request vector
//               last_grant  index of the previous winner
//               en          arbitration enable; grant is 0 when low
//               grant [1:0] one-hot grant
// Revision    : 1.0 - initial release
// ============================================================================
module sm4_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sm4_sbox_sched.sv
`default_nettype none
// ============================================================================
// Module      : sm4_sbox_sched
// Description : Time-shared SM4 tau scheduler. Arbitrates the key-expansion
//               and round-function requesters round-robin, substitutes the
//               four bytes of the accepted word over 4/NUM_SBOX cycles and
//               returns the tagged result through a valid/yumi handshake.
// Ports       : clk_i, reset_i            clock, sync active-high reset
//               key_v_i/key_data_i/key_ready_o  key-expansion request
//               rnd_v_i/rnd_data_i/rnd_ready_o  round-function request
//               v_o/data_o/src_o/yumi_i          result handshake
// Revision    : 1.0 - initial release
// ============================================================================
module sm4_sbox_sched #(
  parameter int NUM_SBOX = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        key_v_i,
  input  logic [31:0] key_data_i,
  output logic        key_ready_o,
  input  logic        rnd_v_i,
  input  logic [31:0] rnd_data_i,
  output logic        rnd_ready_o,
  output logic        v_o,
  output logic [31:0] data_o,
  output logic        src_o,
  input  logic        yumi_i
);

  import sm4_pkg::*;

  localparam int CYCLES = 4 / NUM_SBOX;

  if (!num_sbox_legal(NUM_SBOX)) begin : g_bad_num_sbox
    $error("sm4_sbox_sched: NUM_SBOX must be 1, 2 or 4");
  end

  sbox_sched_state_e r_state, w_state_nxt;
  sm4_word_t         r_word, r_result, w_result_nxt;
  logic              r_src, r_last_grant;
  logic [2:0]        r_cnt;
  logic [1:0]        w_grant;
  logic              w_accept, w_last_step;
  logic [1:0]        w_lane_idx [NUM_SBOX];
  logic [7:0]        w_sbox_in  [NUM_SBOX];
  logic [7:0]        w_sbox_out [NUM_SBOX];

  // Arbitration only happens in IDLE; reset masks it so nothing looks
  // accepted in a cycle whose capture reset would discard.
  sm4_rr_arb2 u_arb (
    .req        ({rnd_v_i, key_v_i}),
    .last_grant (r_last_grant),
    .en         ((r_state == IDLE) && !reset_i),
    .grant      (w_grant)
  );

  assign key_ready_o = w_grant[0];
  assign rnd_ready_o = w_grant[1];
  assign w_accept    = |w_grant;
  assign w_last_step = (r_cnt + 3'(NUM_SBOX)) == 3'd4;

  // Lane j handles byte cnt+j of the captured word.
  for (genvar j = 0; j < NUM_SBOX; j++) begin : g_lane
    assign w_lane_idx[j] = r_cnt[1:0] + 2'(j);
    assign w_sbox_in[j]  = r_word[{w_lane_idx[j], 3'b000} +: 8];
    sbox_memory u_sbox (
      .addr_i (w_sbox_in[j]),
      .data_o (w_sbox_out[j])
    );
  end

  always_comb begin
    w_result_nxt = r_result;
    for (int j = 0; j < NUM_SBOX; j++) begin
      w_result_nxt[{w_lane_idx[j], 3'b000} +: 8] = w_sbox_out[j];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_state_nxt = LOOKUP;
      LOOKUP:  if (w_last_step) w_state_nxt = DONE;
      DONE:    if (yumi_i)      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_word       <= '0;
      r_result     <= '0;
      r_src        <= SM4_SRC_KEY;
      r_last_grant <= SM4_SRC_RND;
      r_cnt        <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && w_accept) begin
        r_word       <= w_grant[1] ? rnd_data_i : key_data_i;
        r_src        <= w_grant[1];
        r_last_grant <= w_grant[1];
        r_cnt        <= '0;
      end else if (r_state == LOOKUP) begin
        r_result <= w_result_nxt;
        r_cnt    <= r_cnt + 3'(NUM_SBOX);
      end
    end
  end

  assign v_o    = (r_state == DONE);
  assign data_o = r_result;
  assign src_o  = r_src;

  a_ready_onehot : assert property (@(posedge clk_i) !(key_ready_o && rnd_ready_o));
  a_yumi_legal   : assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);
  a_result_hold  : assert property (@(posedge clk_i) disable iff (reset_i)
                                    (v_o && !yumi_i) |=> ($stable(data_o) && $stable(src_o)));

  // CYCLES documents the lookup length; the counter compares against 4.
  logic w_unused_cycles;
  assign w_unused_cycles = (CYCLES == 0);

endmodule
`default_nettype wire
